iic_init_seq: RTL and testbench

- Table-driven register-initialisation sequencer sitting directly upstream of the IIC byte-transaction master.
- After power-up or on request, it walks a synchronous ROM of {reg_addr, data} entries and issues one IIC write per entry.
- For each write it drives the master's send / wr / slave-address / reg-address / data inputs and waits for the master's busy flag to complete.
- Supports end-of-table markers, inline delay entries and a busy-handshake timeout.

---
 rtl/iic_init_seq_if.sv | 14 +
 rtl/iic_init_seq.sv | 147 ++++++++++++++
 tb/tb_iic_init_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_init_seq_if.sv
// Command/response link between the init sequencer (master side) and the IIC
// byte-transaction engine (slave side).
interface iic_init_seq_if;
  logic       send;
  logic       wr;
  logic [6:0] slv_addr;
  logic [7:0] reg_addr;
  logic [7:0] data;
  logic       busy;
  logic [7:0] rd_data;

  modport master (output send, wr, slv_addr, reg_addr, data, input busy, rd_data);
  modport slave  (input send, wr, slv_addr, reg_addr, data, output busy, rd_data);
endinterface

// File: rtl/iic_init_seq.sv
// Table-driven IIC register-initialisation sequencer: one write per ROM entry.
// Optional readback verification of every write: define IIC_INIT_READBACK_EN.
module iic_init_seq #(
  parameter int         AW         = 6,
  parameter logic [6:0] SLV_ADDR   = 7'h3C,
  parameter int         PWR_DLY    = 1000,
  parameter bit         AUTO_START = 1'b1,
  parameter int         GAP_CYC    = 250,
  parameter int         DLY_UNIT   = 5000,
  parameter int         BUSY_TO    = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  output logic [AW-1:0]  tbl_addr_o,
  input  logic [15:0]    tbl_data_i,
  iic_init_seq_if.master iic,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [AW-1:0]  err_idx_o
);

  localparam logic [31:0] PWR_LAST   = 32'(PWR_DLY - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);
  localparam logic [31:0] BUSY_LAST  = 32'(BUSY_TO - 1);
  localparam logic [31:0] DLY_UNIT_W = 32'(DLY_UNIT);

  typedef enum logic [3:0] {
    S_PWR_WAIT, S_IDLE, S_FETCH, S_LATCH, S_SEND, S_WAIT_BUSY, S_WAIT_DONE,
`ifdef IIC_INIT_READBACK_EN
    S_RB_SEND, S_RB_WAIT_BUSY, S_RB_WAIT_DONE, S_CHECK,
`endif
    S_GAP, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] idx;
  logic [31:0]   cnt;
  logic [31:0]   dly_prod;
  logic          tbl_end, tbl_dly, cnt_run;

  assign tbl_end    = (tbl_data_i == 16'hFFFF);
  assign tbl_dly    = (tbl_data_i[15:8] == 8'hFE);
  assign dly_prod   = 32'(tbl_data_i[7:0]) * DLY_UNIT_W;
  assign tbl_addr_o = idx;
  assign busy_o     = !(state == S_PWR_WAIT || state == S_IDLE);

`ifdef IIC_INIT_READBACK_EN
  assign iic.send = (state == S_SEND) || (state == S_RB_SEND);
  assign cnt_run  = (state == S_PWR_WAIT) || (state == S_WAIT_BUSY) ||
                    (state == S_RB_WAIT_BUSY) || (state == S_GAP);
`else
  assign iic.send = (state == S_SEND);
  assign cnt_run  = (state == S_PWR_WAIT) || (state == S_WAIT_BUSY) || (state == S_GAP);
`endif

  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_PWR_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so no branch leaves state_next unassigned and no latch is inferred.
    state_next = state;
    unique case (state)
      S_PWR_WAIT: begin
        if (start_i)              state_next = S_FETCH;
        else if (cnt >= PWR_LAST) state_next = AUTO_START ? S_FETCH : S_IDLE;
      end
      S_IDLE:      if (start_i) state_next = S_FETCH;
      S_FETCH:     state_next = S_LATCH;
      S_LATCH: begin
        if (tbl_end)      state_next = S_DONE;
        else if (tbl_dly) state_next = (dly_prod == '0) ? S_NEXT : S_DELAY;
        else              state_next = S_SEND;
      end
      S_SEND:      state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (iic.busy)              state_next = S_WAIT_DONE;
        else if (cnt >= BUSY_LAST) state_next = S_ERROR;
      end
`ifdef IIC_INIT_READBACK_EN
      S_WAIT_DONE:    if (!iic.busy) state_next = S_RB_SEND;
      S_RB_SEND:      state_next = S_RB_WAIT_BUSY;
      S_RB_WAIT_BUSY: begin
        if (iic.busy)              state_next = S_RB_WAIT_DONE;
        else if (cnt >= BUSY_LAST) state_next = S_ERROR;
      end
      S_RB_WAIT_DONE: if (!iic.busy) state_next = S_CHECK;
      S_CHECK:        state_next = (iic.rd_data != iic.data) ? S_ERROR : S_GAP;
`else
      S_WAIT_DONE:    if (!iic.busy) state_next = S_GAP;
`endif
      S_GAP:       if (cnt >= GAP_LAST) state_next = S_NEXT;
      S_DELAY:     if (cnt <= 32'd1) state_next = S_NEXT;
      // The last table slot ends the run instead of wrapping back to entry 0.
      S_NEXT:      state_next = (idx == '1) ? S_DONE : S_FETCH;
      S_DONE:      state_next = S_IDLE;
      S_ERROR:     state_next = S_IDLE;
      default:     state_next = S_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx          <= '0;
      cnt          <= '0;
      iic.wr       <= 1'b1;
      iic.slv_addr <= SLV_ADDR;
      iic.reg_addr <= '0;
      iic.data     <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_idx_o    <= '0;
    end else begin
      // One shared counter: cleared on every state change, loaded for delays.
      if (state_next != state) cnt <= (state_next == S_DELAY) ? dly_prod : '0;
      else if (state == S_DELAY) cnt <= cnt - 32'd1;
      else if (cnt_run) cnt <= cnt + 32'd1;

      if (start_i && !busy_o) begin
        idx       <= '0;
        done_o    <= 1'b0;
        err_o     <= 1'b0;
        err_idx_o <= '0;
      end

      if (state == S_LATCH && !tbl_end && !tbl_dly) begin
        iic.wr       <= 1'b1;
        iic.reg_addr <= tbl_data_i[15:8];
        iic.data     <= tbl_data_i[7:0];
      end
`ifdef IIC_INIT_READBACK_EN
      if (state == S_WAIT_DONE && !iic.busy) iic.wr <= 1'b0;
`endif
      if (state == S_NEXT && idx != '1) idx <= idx + 1'b1;
      if (state == S_DONE) done_o <= 1'b1;
      if (state == S_ERROR) begin
        err_o     <= 1'b1;
        err_idx_o <= idx;
      end
    end
  end

endmodule

// File: tb/tb_iic_init_seq.sv
// Directed bench for iic_init_seq: bus-model IIC master, ROM model, scenario table
// plus hand-written reset/abort/readback sequences.
module tb_iic_init_seq;
  localparam int AW = 2;

  typedef struct {
    logic [63:0] tbl;        // entry k in bits [16k +: 16]
    int          fail_at;    // write index the master never acknowledges, -1 none
    int          n_wr;
    bit          done;
    bit          err;
    int          err_idx;
    logic [7:0]  last_reg;
    logic [7:0]  last_data;
    int          lat_lo;     // first send, cycles after start is sampled
    int          lat_hi;
  } scen_t;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] tbl_addr, err_idx;
  logic [15:0]   tbl_data;
  logic          busy, done, err;
  logic [15:0]   rom [4];
  logic [7:0]    mem [256];

  int errors = 0, checks = 0, cyc = 0, start_cyc = 0;
  int n_wr, n_rd, first_send_cyc, last_send_cyc, err_cyc, fail_at = -1;
  logic [7:0] first_reg, first_data, last_reg, last_data, corrupt_reg = 8'h00;
  bit corrupt_en = 1'b0, wrap_seen;

  iic_init_seq_if bus();

  iic_init_seq #(
    .AW(AW), .SLV_ADDR(7'h3C), .PWR_DLY(10), .AUTO_START(1'b1),
    .GAP_CYC(4), .DLY_UNIT(10), .BUSY_TO(64)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data), .iic(bus),
    .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tbl_data <= rom[tbl_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0; n_rd = 0; wrap_seen = 1'b0;
    first_send_cyc = -1; last_send_cyc = -1; err_cyc = -1;
    first_reg = 8'h00; first_data = 8'h00; last_reg = 8'h00; last_data = 8'h00;
  endtask

  task automatic load_rom(input logic [63:0] t);
    for (int k = 0; k < 4; k++) rom[k] = t[16*k +: 16];
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; start_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_busy(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!busy && n < budget) begin @(negedge clk); n++; end
    check({name, "_busy"}, busy, 1'b1);
  endtask

  // IIC master model: busy rises 2 cycles after send, stays high 3 cycles.
  initial begin
    int ph = 0, cnt = 0;
    logic m_wr;
    logic [7:0] m_reg, m_data;
    bus.busy = 1'b0; bus.rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ph = 0; bus.busy = 1'b0;
      end else if (bus.send) begin
        m_wr = bus.wr; m_reg = bus.reg_addr; m_data = bus.data;
        check("slv_addr", bus.slv_addr, 7'h3C);
        if (first_send_cyc < 0) begin
          first_send_cyc = cyc; first_reg = m_reg; first_data = m_data;
        end
        last_send_cyc = cyc;
        ph = 1; cnt = 2;
        if (m_wr) begin
          last_reg = m_reg; last_data = m_data;
          if (n_wr == fail_at) ph = 0;
          n_wr++;
        end else n_rd++;
      end else if (ph == 1) begin
        cnt--;
        if (cnt == 0) begin bus.busy = 1'b1; cnt = 3; ph = 2; end
      end else if (ph == 2) begin
        cnt--;
        if (cnt == 0) begin
          if (m_wr) mem[m_reg] = m_data;
          else bus.rd_data = mem[m_reg] - ((corrupt_en && m_reg == corrupt_reg) ? 8'd1 : 8'd0);
          check("hold_reg", bus.reg_addr, m_reg);
          check("hold_data", bus.data, m_data);
          check("hold_wr", bus.wr, m_wr);
          bus.busy = 1'b0; ph = 0;
        end
      end
    end
  end

  // Watches for an address wrap inside one run and timestamps err_o rising.
  initial begin
    logic pb = 1'b0, pe = 1'b0;
    logic [AW-1:0] pa = '0;
    forever begin
      @(negedge clk);
      if (busy && pb && pa == 2'd3 && tbl_addr == 2'd0) wrap_seen = 1'b1;
      if (err && !pe) err_cyc = cyc;
      pb = busy; pa = tbl_addr; pe = err;
    end
  end

  function automatic scen_t mk(input logic [15:0] e0, e1, e2, e3, input int fail, nwr,
                               input bit dn, er, input int eidx,
                               input logic [7:0] lr, ld, input int lo, hi);
    scen_t s;
    s.tbl = {e3, e2, e1, e0}; s.fail_at = fail; s.n_wr = nwr; s.done = dn; s.err = er;
    s.err_idx = eidx; s.last_reg = lr; s.last_data = ld; s.lat_lo = lo; s.lat_hi = hi;
    return s;
  endfunction

  initial begin
    scen_t sc [7];
    sc[0] = mk(16'h1180, 16'h2201, 16'hFFFF, 16'h0000, -1, 2, 1, 0, 0, 8'h22, 8'h01, 2, 2);
    sc[1] = mk(16'hFE03, 16'h0555, 16'hFFFF, 16'h0000, -1, 1, 1, 0, 0, 8'h05, 8'h55, 32, 40);
    sc[2] = mk(16'hAA01, 16'hBB02, 16'hCC03, 16'hDD04, -1, 4, 1, 0, 0, 8'hDD, 8'h04, 2, 2);
    sc[3] = mk(16'h1180, 16'h2201, 16'hFFFF, 16'h0000,  0, 1, 0, 1, 0, 8'h11, 8'h80, 2, 2);
    sc[4] = mk(16'hFFFF, 16'h1234, 16'h0000, 16'h0000, -1, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
    sc[5] = mk(16'hFE00, 16'h3344, 16'hFFFF, 16'h0000, -1, 1, 1, 0, 0, 8'h33, 8'h44, 5, 5);
    sc[6] = mk(16'h1122, 16'hFE01, 16'h3344, 16'h5566,  1, 2, 0, 1, 2, 8'h33, 8'h44, 2, 2);

    // Reset values, power-up wait, auto-start run.
    clear_stats();
    load_rom(sc[0].tbl);
    repeat (3) @(negedge clk);
    check("rst_send", bus.send, 1'b0);
    check("rst_wr", bus.wr, 1'b1);
    check("rst_slv", bus.slv_addr, 7'h3C);
    check("rst_reg", bus.reg_addr, 8'h00);
    check("rst_data", bus.data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_idx", err_idx, 2'd0);
    check("rst_tbl_addr", tbl_addr, 2'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("pwr_wait_busy", busy, 1'b0);
    check("pwr_wait_sends", n_wr, 0);
    wait_busy(20, "auto");
    wait_idle(1000, "auto");
    check("auto_n_wr", n_wr, 2);
    check("auto_first_reg", first_reg, 8'h11);
    check("auto_first_data", first_data, 8'h80);
    check("auto_last_reg", last_reg, 8'h22);
    check("auto_last_data", last_data, 8'h01);
    check("auto_done", done, 1'b1);
    check("auto_err", err, 1'b0);

    for (int i = 0; i < 7; i++) begin
      int exp_rd;
`ifdef IIC_INIT_READBACK_EN
      exp_rd = sc[i].err ? sc[i].n_wr - 1 : sc[i].n_wr;
`else
      exp_rd = 0;
`endif
      load_rom(sc[i].tbl);
      fail_at = sc[i].fail_at;
      clear_stats();
      pulse_start();
      wait_idle(1000, $sformatf("s%0d", i));
      check($sformatf("s%0d_done", i), done, sc[i].done);
      check($sformatf("s%0d_err", i), err, sc[i].err);
      check($sformatf("s%0d_err_idx", i), err_idx, sc[i].err_idx);
      check($sformatf("s%0d_n_wr", i), n_wr, sc[i].n_wr);
      check($sformatf("s%0d_n_rd", i), n_rd, exp_rd);
      check($sformatf("s%0d_last_reg", i), last_reg, sc[i].last_reg);
      check($sformatf("s%0d_last_data", i), last_data, sc[i].last_data);
      check($sformatf("s%0d_wrap", i), wrap_seen, 1'b0);
      if (sc[i].n_wr > 0)
        check_range($sformatf("s%0d_latency", i), first_send_cyc - start_cyc, sc[i].lat_lo, sc[i].lat_hi);
      if (sc[i].err)
        check_range($sformatf("s%0d_timeout", i), err_cyc - last_send_cyc, 64, 70);
    end
    fail_at = -1;

    // Reset while entry 1 is in flight, then restart from entry 0 after the power-up wait.
    load_rom(sc[0].tbl);
    clear_stats();
    pulse_start();
    begin
      int n = 0;
      while (!(n_wr == 2 && bus.busy) && n < 500) begin @(posedge clk); #2; n++; end
      check("mid_reached", n_wr, 2);
    end
    #1 rst = 1'b1;
    #1;
    check("mid_rst_send", bus.send, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wr", bus.wr, 1'b1);
    check("mid_rst_reg", bus.reg_addr, 8'h00);
    check("mid_rst_data", bus.data, 8'h00);
    check("mid_rst_tbl_addr", tbl_addr, 2'd0);
    check("mid_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stats();
    repeat (5) @(negedge clk);
    check("mid_pwr_busy", busy, 1'b0);
    wait_busy(20, "mid_auto");
    wait_idle(1000, "mid_auto");
    check("mid_first_reg", first_reg, 8'h11);
    check("mid_n_wr", n_wr, 2);
    check("mid_done", done, 1'b1);

    // start_i during the power-up wait launches the run at once.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    pulse_start();
    check("abort_busy", busy, 1'b1);
    wait_idle(1000, "abort");
    check("abort_latency", first_send_cyc - start_cyc, 2);
    check("abort_done", done, 1'b1);

`ifdef IIC_INIT_READBACK_EN
    // Readback mismatch on entry 0 (0x80 written, 0x7F returned).
    corrupt_reg = 8'h11; corrupt_en = 1'b1;
    clear_stats();
    pulse_start();
    wait_idle(1000, "rb_bad");
    check("rb_bad_err", err, 1'b1);
    check("rb_bad_err_idx", err_idx, 2'd0);
    check("rb_bad_done", done, 1'b0);
    check("rb_bad_n_wr", n_wr, 1);
    check("rb_bad_n_rd", n_rd, 1);
    corrupt_en = 1'b0;
    clear_stats();
    pulse_start();
    wait_idle(1000, "rb_good");
    check("rb_good_done", done, 1'b1);
    check("rb_good_err", err, 1'b0);
    check("rb_good_n_wr", n_wr, 2);
    check("rb_good_n_rd", n_rd, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
